// File: rtl/for_loop_pkg.sv
// rtl/for_loop_pkg.sv - shared types and width helpers for the datapath sweep sequencer
package for_loop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sweep_state_e;

  // Checksum width: wide enough that a full sweep of maximal samples never wraps
  function automatic int sig_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/sweep_settle_timer.sv
// rtl/sweep_settle_timer.sv - settle counter that flags the last cycle of each input hold
module sweep_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/for_loop_sweep_ctrl.sv
// rtl/for_loop_sweep_ctrl.sv - walks the datapath input through every code, captures and checksums results
module for_loop_sweep_ctrl
  import for_loop_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_start,
  input  logic                          i_abort,
  output logic [WIDTH-1:0]              o_dp_in,
  input  logic [WIDTH-1:0]              i_dp_out,
  output logic                          o_busy,
  output logic                          o_done,
  output logic                          o_sample_valid,
  output logic [WIDTH-1:0]              o_sample_idx,
  output logic [WIDTH-1:0]              o_sample_data,
  output logic [sig_width(WIDTH)-1:0]   o_sig
);

  localparam int SW = sig_width(WIDTH);
  localparam logic [WIDTH-1:0] LAST_VEC = '1;

  sweep_state_e r_state;
  sweep_state_e w_next;
  logic         w_launch;
  logic         w_capture;
  logic         w_abort_run;
  logic         w_expire;

  logic [WIDTH-1:0] r_dp_in;
  logic             r_sample_valid;
  logic [WIDTH-1:0] r_sample_idx;
  logic [WIDTH-1:0] r_sample_data;
  logic [SW-1:0]    r_sig;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_launch  = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !i_abort) begin
          w_next   = RUN;
          w_launch = 1'b1;
        end
      end
      RUN: begin
        // abort wins over a coinciding capture, so that sample is simply dropped
        if (i_abort) begin
          w_next = IDLE;
        end else if (w_expire) begin
          w_capture = 1'b1;
          if (r_dp_in == LAST_VEC) begin
            w_next = DONE;
          end
        end
      end
      DONE: w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_abort_run = (r_state == RUN) && i_abort;

  sweep_settle_timer #(
    .SETTLE (SETTLE)
  ) u_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_launch | w_abort_run),
    .i_en     (r_state == RUN),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dp_in        <= '0;
      r_sample_valid <= 1'b0;
      r_sample_idx   <= '0;
      r_sample_data  <= '0;
      r_sig          <= '0;
    end else begin
      r_sample_valid <= w_capture;
      if (w_launch) begin
        r_dp_in <= '0;
        r_sig   <= '0;
      end else if (w_abort_run) begin
        r_dp_in <= '0;
      end else if (w_capture) begin
        r_sample_data <= i_dp_out;
        r_sample_idx  <= r_dp_in;
        r_sig         <= r_sig + SW'(i_dp_out);
        r_dp_in       <= (r_dp_in == LAST_VEC) ? '0 : r_dp_in + 1'b1;
      end
    end
  end

  assign o_dp_in        = r_dp_in;
  assign o_busy         = (r_state == RUN);
  assign o_done         = (r_state == DONE);
  assign o_sample_valid = r_sample_valid;
  assign o_sample_idx   = r_sample_idx;
  assign o_sample_data  = r_sample_data;
  assign o_sig          = r_sig;

endmodule

// File: tb/tb_for_loop_sweep_ctrl.sv
// tb/tb_for_loop_sweep_ctrl.sv - randomized self-checking bench for the sweep sequencer
module tb_for_loop_sweep_ctrl;

  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       start  [NI];
  logic       abort  [NI];
  logic [3:0] dp_in  [NI];
  logic [3:0] dp_out [NI];
  logic       busy   [NI];
  logic       done   [NI];
  logic       sv     [NI];
  logic [3:0] s_idx  [NI];
  logic [3:0] s_data [NI];
  logic [7:0] sig    [NI];
  logic [3:0] lut    [NI][16];

  int total = 0;
  int bad   = 0;

  function automatic int settle_of(input int g);
    return (g == 0) ? 2 : (g == 2) ? 3 : 1;
  endfunction

  // 0: S=2 comb, 1: S=1 comb, 2: S=3 two-cycle datapath, 3: S=1 two-cycle datapath
  generate
    for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int SET = (g == 0) ? 2 : (g == 2) ? 3 : 1;
      for_loop_sweep_ctrl #(.WIDTH(4), .SETTLE(SET)) u_dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start[g]),
        .i_abort        (abort[g]),
        .o_dp_in        (dp_in[g]),
        .i_dp_out       (dp_out[g]),
        .o_busy         (busy[g]),
        .o_done         (done[g]),
        .o_sample_valid (sv[g]),
        .o_sample_idx   (s_idx[g]),
        .o_sample_data  (s_data[g]),
        .o_sig          (sig[g])
      );
      if (g >= 2) begin : g_dly
        logic [3:0] d1 = '0;
        logic [3:0] d2 = '0;
        always @(posedge clk) begin
          d1 <= lut[g][dp_in[g]];
          d2 <= d1;
        end
        assign dp_out[g] = d2;
      end else begin : g_comb
        assign dp_out[g] = lut[g][dp_in[g]];
      end
    end
  endgenerate

  int         samp_n [NI] = '{default: 0};
  int         done_n [NI] = '{default: 0};
  int         m_cyc  [NI][256];
  logic [3:0] m_idx  [NI][256];
  logic [3:0] m_data [NI][256];
  logic [7:0] m_sig  [NI][256];
  int         dn_cyc [NI];
  logic [7:0] dn_sig [NI];
  logic       dn_busy[NI];

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (sv[g]) begin
        m_cyc[g][samp_n[g] % 256]  <= cyc;
        m_idx[g][samp_n[g] % 256]  <= s_idx[g];
        m_data[g][samp_n[g] % 256] <= s_data[g];
        m_sig[g][samp_n[g] % 256]  <= sig[g];
        samp_n[g] <= samp_n[g] + 1;
      end
      if (done[g]) begin
        dn_cyc[g]  <= cyc;
        dn_sig[g]  <= sig[g];
        dn_busy[g] <= busy[g];
        done_n[g]  <= done_n[g] + 1;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic go(input int g, output int t);
    start[g] = 1'b1;
    t = cyc;
    step();
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int dbase, output bit timed_out);
    int n;
    n = 0;
    while (done_n[g] == dbase && n < 300) begin
      step();
      n++;
    end
    timed_out = (done_n[g] == dbase);
  endtask

  task automatic fill_random(input int g);
    for (int i = 0; i < 16; i++) lut[g][i] = 4'($urandom_range(0, 15));
  endtask

  task automatic fill_perm(input int g);
    logic [3:0] tmp;
    int j;
    for (int i = 0; i < 16; i++) lut[g][i] = 4'(i);
    for (int i = 15; i > 0; i--) begin
      j = $urandom_range(0, i);
      tmp = lut[g][i];
      lut[g][i] = lut[g][j];
      lut[g][j] = tmp;
    end
  endtask

  task automatic test_reset();
    step();
    for (int g = 0; g < NI; g++) begin
      total++;
      if ({dp_in[g], busy[g], done[g], sv[g], s_idx[g], s_data[g], sig[g]} !== 25'd0) begin
        bad++;
        $display("FAIL reset_state inst=%0d got dp_in=%0h busy=%0b done=%0b sv=%0b idx=%0h data=%0h sig=%0h exp all zero",
                 g, dp_in[g], busy[g], done[g], sv[g], s_idx[g], s_data[g], sig[g]);
      end
    end
    rst = 1'b0;
    step();
  endtask

  // kinds: 0 identity on S=2, 1 constant F on S=1, 2/3 random luts on S=2/S=1
  task automatic test_full_sweeps();
    int g, s, t, base, dbase, exp_sig;
    bit to;
    for (int kind = 0; kind < 4; kind++) begin
      g = kind % 2;
      s = settle_of(g);
      for (int i = 0; i < 16; i++)
        lut[g][i] = (kind == 0) ? 4'(i) : (kind == 1) ? 4'hF : 4'($urandom_range(0, 15));
      step();
      base  = samp_n[g];
      dbase = done_n[g];
      go(g, t);
      wait_done(g, dbase, to);
      total++;
      if (to) begin
        bad++;
        $display("FAIL sweep_timeout kind=%0d got no done exp done by cycle %0d", kind, t + 16 * s + 1);
        continue;
      end
      step();
      total++;
      if (samp_n[g] - base !== 16) begin
        bad++;
        $display("FAIL sample_count kind=%0d got %0d exp 16", kind, samp_n[g] - base);
      end
      exp_sig = 0;
      for (int k = 0; k < 16; k++) begin
        exp_sig = (exp_sig + int'(lut[g][k])) % 256;
        total++;
        if (m_idx[g][(base + k) % 256] !== 4'(k) || m_data[g][(base + k) % 256] !== lut[g][k] ||
            m_sig[g][(base + k) % 256] !== 8'(exp_sig) || m_cyc[g][(base + k) % 256] !== t + (k + 1) * s + 1) begin
          bad++;
          $display("FAIL sample kind=%0d k=%0d got idx=%0h data=%0h sig=%0h cyc=%0d exp idx=%0h data=%0h sig=%0h cyc=%0d",
                   kind, k, m_idx[g][(base + k) % 256], m_data[g][(base + k) % 256], m_sig[g][(base + k) % 256],
                   m_cyc[g][(base + k) % 256], k, lut[g][k], exp_sig, t + (k + 1) * s + 1);
        end
      end
      total++;
      if (dn_cyc[g] !== t + 16 * s + 1 || dn_sig[g] !== 8'(exp_sig) || dn_busy[g] !== 1'b0) begin
        bad++;
        $display("FAIL done_pulse kind=%0d got cyc=%0d sig=%0h busy=%0b exp cyc=%0d sig=%0h busy=0",
                 kind, dn_cyc[g], dn_sig[g], dn_busy[g], t + 16 * s + 1, exp_sig);
      end
      if (kind < 2) begin
        total++;
        if (dn_sig[g] !== ((kind == 0) ? 8'h78 : 8'hF0)) begin
          bad++;
          $display("FAIL fixed_sig kind=%0d got %0h exp %0h", kind, dn_sig[g], (kind == 0) ? 8'h78 : 8'hF0);
        end
      end
    end
  endtask

  task automatic test_abort();
    int t, base, dbase;
    for (int i = 0; i < 16; i++) lut[0][i] = 4'(i);
    step();
    base  = samp_n[0];
    dbase = done_n[0];
    go(0, t);
    while (cyc < t + 14) step();
    total++;
    if (samp_n[0] - base !== 6) begin
      bad++;
      $display("FAIL abort_presamples got %0d exp 6", samp_n[0] - base);
    end
    abort[0] = 1'b1;
    step();
    abort[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b0 || dp_in[0] !== 4'h0 || done[0] !== 1'b0 || sig[0] !== 8'h0F) begin
      bad++;
      $display("FAIL abort_state got busy=%0b dp_in=%0h done=%0b sig=%0h exp busy=0 dp_in=0 done=0 sig=0f",
               busy[0], dp_in[0], done[0], sig[0]);
    end
    repeat (40) step();
    total++;
    if (samp_n[0] - base !== 6 || done_n[0] !== dbase || sig[0] !== 8'h0F) begin
      bad++;
      $display("FAIL abort_quiet got samples=%0d dones=%0d sig=%0h exp samples=6 dones=0 sig=0f",
               samp_n[0] - base, done_n[0] - dbase, sig[0]);
    end
  endtask

  task automatic test_start_ignored();
    int t, t2, base, dbase, exp_sig;
    bit to;
    fill_random(0);
    step();
    dbase = done_n[0];
    go(0, t);
    while (cyc < t + 10) step();
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    wait_done(0, dbase, to);
    total++;
    if (to || dn_cyc[0] !== t + 33) begin
      bad++;
      $display("FAIL start_in_run got done_cyc=%0d timeout=%0b exp done_cyc=%0d", dn_cyc[0], to, t + 33);
    end
    start[0] = 1'b1;
    step();
    start[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done got busy=%0b exp 0", busy[0]);
    end
    start[0] = 1'b1;
    abort[0] = 1'b1;
    step();
    start[0] = 1'b0;
    abort[0] = 1'b0;
    total++;
    if (busy[0] !== 1'b0) begin
      bad++;
      $display("FAIL start_abort_idle got busy=%0b exp 0", busy[0]);
    end
    fill_random(0);
    base  = samp_n[0];
    dbase = done_n[0];
    go(0, t2);
    wait_done(0, dbase, to);
    step();
    exp_sig = 0;
    for (int k = 0; k < 16; k++) exp_sig += int'(lut[0][k]);
    total++;
    if (to || m_sig[0][base % 256] !== lut[0][0] || dn_sig[0] !== 8'(exp_sig) || dn_cyc[0] !== t2 + 33) begin
      bad++;
      $display("FAIL second_sweep got first_sig=%0h final_sig=%0h done_cyc=%0d exp first_sig=%0h final_sig=%0h done_cyc=%0d",
               m_sig[0][base % 256], dn_sig[0], dn_cyc[0], lut[0][0], 8'(exp_sig), t2 + 33);
    end
  endtask

  task automatic test_delayed();
    int t, base2, base3, d2, d3, mism;
    bit to;
    fill_perm(2);
    for (int i = 0; i < 16; i++) lut[3][i] = lut[2][i];
    step();
    base2 = samp_n[2];
    base3 = samp_n[3];
    d2    = done_n[2];
    d3    = done_n[3];
    start[3] = 1'b1;
    go(2, t);
    start[3] = 1'b0;
    wait_done(2, d2, to);
    step();
    total++;
    if (to || done_n[3] === d3 || samp_n[2] - base2 !== 16 || samp_n[3] - base3 !== 16) begin
      bad++;
      $display("FAIL delayed_run got timeout=%0b samples2=%0d samples3=%0d exp 0 16 16",
               to, samp_n[2] - base2, samp_n[3] - base3);
    end
    for (int k = 0; k < 16; k++) begin
      total++;
      if (m_data[2][(base2 + k) % 256] !== lut[2][k] || m_idx[2][(base2 + k) % 256] !== 4'(k)) begin
        bad++;
        $display("FAIL delayed_s3 k=%0d got idx=%0h data=%0h exp idx=%0h data=%0h",
                 k, m_idx[2][(base2 + k) % 256], m_data[2][(base2 + k) % 256], k, lut[2][k]);
      end
    end
    mism = 0;
    for (int k = 0; k < 16; k++)
      if (m_data[3][(base3 + k) % 256] !== lut[3][k]) mism++;
    total++;
    if (mism == 0) begin
      bad++;
      $display("FAIL sample_point_s1 got mismatches=0 exp nonzero for a two-cycle datapath");
    end
  endtask

  task automatic test_async_reset();
    int t, base;
    for (int i = 0; i < 16; i++) lut[0][i] = 4'(15 - i);
    step();
    go(0, t);
    repeat (8) step();
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({dp_in[0], busy[0], done[0], sv[0], s_idx[0], s_data[0], sig[0]} !== 25'd0) begin
      bad++;
      $display("FAIL async_reset got dp_in=%0h busy=%0b done=%0b sv=%0b idx=%0h data=%0h sig=%0h exp all zero",
               dp_in[0], busy[0], done[0], sv[0], s_idx[0], s_data[0], sig[0]);
    end
    step();
    rst = 1'b0;
    base = samp_n[0];
    repeat (5) step();
    total++;
    if (busy[0] !== 1'b0 || samp_n[0] !== base || dp_in[0] !== 4'h0) begin
      bad++;
      $display("FAIL post_reset_idle got busy=%0b new_samples=%0d dp_in=%0h exp 0 0 0",
               busy[0], samp_n[0] - base, dp_in[0]);
    end
  endtask

  initial begin
    for (int g = 0; g < NI; g++) begin
      start[g] = 1'b0;
      abort[g] = 1'b0;
      for (int i = 0; i < 16; i++) lut[g][i] = 4'(i);
    end
    test_reset();
    test_full_sweeps();
    test_abort();
    test_start_ignored();
    test_delayed();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/for_loop_sweep_ctrl.md
# for_loop_sweep_ctrl

Sequencer that owns the input of the `for_loop_test_4` datapath. On `start` it walks `dp_in` through every value 0 to 2^WIDTH−1 and holds each value for SETTLE cycles. At the end of each hold it captures `dp_out`, streams the sample out, and adds it into a 2·WIDTH-bit checksum. It sits between a test/config master and the datapath instance, so the datapath can be exercised in silicon with no external stimulus.

## Interface
- `WIDTH`, default 4: datapath input/output width; legal range 1–16.
- `SETTLE`, default 2: cycles each input value is held before `dp_out` is sampled; legal range ≥1.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep; honoured only in IDLE.
- `abort`  in  1  cancel a sweep in progress; wins over `start`.
- `dp_in`  out  WIDTH  registered drive to the datapath input.
- `dp_out`  in  WIDTH  datapath result.
- `busy`  out  1  high while a sweep is in progress.
- `done`  out  1  one-cycle pulse when a sweep completes.
- `sample_valid`  out  1  one-cycle pulse per captured sample.
- `sample_idx`  out  WIDTH  `dp_in` value that produced the current sample.
- `sample_data`  out  WIDTH  captured `dp_out`.
- `sig`  out  2·WIDTH  running checksum: sum of all samples in the current sweep, modulo 2^(2·WIDTH).

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 and `abort`=0 → RUN.
  - On that edge: `dp_in`←0, `sig`←0, settle counter←0.
- **RUN:** the settle counter counts 0…SETTLE−1. On the edge where the counter equals SETTLE−1:
  - `sample_data`←`dp_out`, `sample_idx`←`dp_in`, `sample_valid`←1.
  - `sig`←`sig` + zero-extended `dp_out`.
  - Counter←0.
  - If `dp_in`=2^WIDTH−1: `dp_in`←0 and go to DONE. Otherwise `dp_in`←`dp_in`+1.
- **DONE:** `done`=1 for exactly one cycle, then IDLE. `start` is ignored in DONE.
- **`abort`:** in RUN, `abort` → IDLE on the next edge.
  - `dp_in`←0 and the counter clears.
  - `sig` keeps its partial value; no `done` pulse.
  - A capture that coincides with `abort` is dropped.
- **`start` while busy:** ignored; `start` is a level, not latched.
- **Output decode:** `busy`=1 exactly in RUN. `done`=1 exactly in DONE.

## Timing
- **Reset values:** `dp_in`=0, `busy`=0, `done`=0, `sample_valid`=0, `sample_idx`=0, `sample_data`=0, `sig`=0, state IDLE.
- **Reset mid-sweep:** same values immediately, regardless of `clk`.
- **Start accepted at the edge ending cycle T:**
  - `busy`=1 from cycle T+1.
  - Vector k is driven during cycles T+1+k·SETTLE … T+(k+1)·SETTLE.
  - `dp_out` for vector k is sampled at the edge ending cycle T+(k+1)·SETTLE.
  - That sample is presented (`sample_valid`=1) in cycle T+(k+1)·SETTLE+1.
- **Sweep completion:**
  - `done`, the last `sample_valid`, and the final `sig` all appear in cycle T+2^WIDTH·SETTLE+1.
  - `busy`=0 in that same cycle.
  - Earliest next accepted `start` is in cycle T+2^WIDTH·SETTLE+2.
- **Datapath combinational path:** `dp_out` must settle within SETTLE cycles of a `dp_in` change.
- **Width rules:** `sig` cannot overflow for a full sweep (2^WIDTH·(2^WIDTH−1) < 2^(2·WIDTH)). The counter is ⌈log2(SETTLE)⌉ bits, minimum 1. Wrap of `dp_in` is detected by comparison, not by carry-out.

## Structure
- **Package `for_loop_pkg`:**
  - `sweep_state_e` enum (IDLE, RUN, DONE).
  - Function `sig_width(WIDTH)` = 2·WIDTH.
- **Sub-module `sweep_settle_timer`:**
  - Parameter SETTLE.
  - Inputs `clk`, `rst`, `clr`, `en`.
  - Output `expire`, high when the count equals SETTLE−1.
- **Top level:** the FSM, the `dp_in` counter, the capture registers and the accumulator stay in `for_loop_sweep_ctrl`.

## Test plan
- **Identity datapath** (`dp_out`=`dp_in`), WIDTH=4, SETTLE=2, start at cycle 0 → 16 `sample_valid` pulses 2 cycles apart, `sample_idx`=`sample_data`=0…15, `done` in cycle 33, `sig`=8'h78.
- **Constant datapath** `dp_out`=4'hF, SETTLE=1 → 16 consecutive `sample_valid` cycles, `done` in cycle 17, `sig`=8'hF0.
- **Abort:** assert `abort` in the cycle after the sample for `idx`=5 is presented → next cycle `busy`=0, `dp_in`=0, no `done`, `sig` equal to the sum of samples 0–5 (8'h0F for identity).
- **`start` during RUN or DONE** → ignored; `start` and `abort` together in IDLE → stays IDLE. A second sweep after `done` begins with `sig`=0.
- **Async `rst` mid-sweep** (asserted between edges) → all outputs at reset values before the next `clk` edge, then IDLE.
- **SETTLE=3 with a datapath delayed by 2 cycles** → all samples correct; the same datapath with SETTLE=1 → the bench detects a mismatch, proving the sample point.
